// File: rtl/bellek_hakemi.sv
// rtl/bellek_hakemi.sv - N-channel memory request arbiter, one transaction outstanding
// Optional response timeout enabled by defining HAKEM_ZAMAN_ASIMI_EN.
module bellek_hakemi #(
  parameter int KANAL_SAYISI    = 4,
  parameter int ADRES_GENISLIGI = 32,
  parameter int VERI_GENISLIGI  = 32,
  parameter int MASKE_GENISLIGI = 4,
  parameter int ZAMAN_ASIMI     = 255
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    oncelik_modu_i,
  input  logic [KANAL_SAYISI-1:0]                 istek_gecerli_i,
  input  logic [KANAL_SAYISI*ADRES_GENISLIGI-1:0] istek_adres_i,
  input  logic [KANAL_SAYISI-1:0]                 istek_yaz_i,
  input  logic [KANAL_SAYISI*MASKE_GENISLIGI-1:0] istek_maske_i,
  input  logic [KANAL_SAYISI*VERI_GENISLIGI-1:0]  istek_veri_i,
  output logic [KANAL_SAYISI-1:0]                 yanit_hazir_o,
  output logic [VERI_GENISLIGI-1:0]               yanit_veri_o,
  output logic                                    hata_o,
  output logic                                    bellek_gecerli_o,
  output logic [ADRES_GENISLIGI-1:0]              bellek_adres_o,
  output logic                                    bellek_yaz_o,
  output logic [MASKE_GENISLIGI-1:0]              bellek_maske_o,
  output logic [VERI_GENISLIGI-1:0]               bellek_veri_o,
  input  logic                                    bellek_kabul_i,
  input  logic                                    bellek_yanit_gecerli_i,
  input  logic [VERI_GENISLIGI-1:0]               bellek_yanit_veri_i
);

  localparam int PW = $clog2(KANAL_SAYISI);

  if (KANAL_SAYISI < 2 || ZAMAN_ASIMI < 1 || MASKE_GENISLIGI * 8 != VERI_GENISLIGI) begin : g_hatali_parametre
    $error("bellek_hakemi: invalid parameter set");
  end

  typedef enum logic [1:0] {BOSTA, ISTEK, YANIT} durum_t;

  durum_t          durum;
  logic [PW-1:0]   isaretci;
  logic [PW-1:0]   hibe;
  logic [PW-1:0]   secim;
  logic [PW-1:0]   aday;
  logic            secim_var;
  logic            zaman_asimi;

  logic [ADRES_GENISLIGI-1:0] adres_k [KANAL_SAYISI];
  logic [MASKE_GENISLIGI-1:0] maske_k [KANAL_SAYISI];
  logic [VERI_GENISLIGI-1:0]  veri_k  [KANAL_SAYISI];

  for (genvar c = 0; c < KANAL_SAYISI; c++) begin : g_ayir
    assign adres_k[c] = istek_adres_i[c*ADRES_GENISLIGI +: ADRES_GENISLIGI];
    assign maske_k[c] = istek_maske_i[c*MASKE_GENISLIGI +: MASKE_GENISLIGI];
    assign veri_k[c]  = istek_veri_i[c*VERI_GENISLIGI +: VERI_GENISLIGI];
  end

  // Scan starts at 0 for fixed priority, at the pointer for round-robin.
  always_comb begin
    secim     = '0;
    secim_var = 1'b0;
    aday      = '0;
    for (int i = 0; i < KANAL_SAYISI; i++) begin
      aday = oncelik_modu_i ? PW'(i) : PW'((int'(isaretci) + i) % KANAL_SAYISI);
      if (!secim_var && istek_gecerli_i[aday]) begin
        secim     = aday;
        secim_var = 1'b1;
      end
    end
  end

  function automatic logic [PW-1:0] sonraki(input logic [PW-1:0] k);
    if (int'(k) == KANAL_SAYISI - 1) return '0;
    return k + PW'(1);
  endfunction

  function automatic logic [KANAL_SAYISI-1:0] tek_bit(input logic [PW-1:0] k);
    return {{(KANAL_SAYISI-1){1'b0}}, 1'b1} << k;
  endfunction

`ifdef HAKEM_ZAMAN_ASIMI_EN
  localparam int SW = $clog2(ZAMAN_ASIMI + 1);
  localparam logic [SW-1:0] SAYAC_SON = SW'(ZAMAN_ASIMI - 1);

  logic [SW-1:0] sayac;

  // Fires on the cycle the count would reach the limit; a response in that cycle still wins.
  assign zaman_asimi = (durum != BOSTA) && (sayac == SAYAC_SON) &&
                       !(durum == YANIT && bellek_yanit_gecerli_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sayac  <= '0;
      hata_o <= 1'b0;
    end else begin
      hata_o <= zaman_asimi;
      if (durum == BOSTA) sayac <= '0;
      else                sayac <= sayac + SW'(1);
    end
  end
`else
  assign zaman_asimi = 1'b0;
  assign hata_o      = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum            <= BOSTA;
      isaretci         <= '0;
      hibe             <= '0;
      bellek_gecerli_o <= 1'b0;
      bellek_adres_o   <= '0;
      bellek_yaz_o     <= 1'b0;
      bellek_maske_o   <= '0;
      bellek_veri_o    <= '0;
      yanit_hazir_o    <= '0;
      yanit_veri_o     <= '0;
    end else begin
      yanit_hazir_o <= '0;
      case (durum)
        BOSTA: begin
          if (secim_var) begin
            hibe             <= secim;
            bellek_adres_o   <= adres_k[secim];
            bellek_yaz_o     <= istek_yaz_i[secim];
            bellek_maske_o   <= maske_k[secim];
            bellek_veri_o    <= veri_k[secim];
            bellek_gecerli_o <= 1'b1;
            durum            <= ISTEK;
            if (!oncelik_modu_i) isaretci <= sonraki(secim);
          end
        end
        ISTEK: begin
          if (zaman_asimi) begin
            yanit_hazir_o    <= tek_bit(hibe);
            yanit_veri_o     <= '0;
            bellek_gecerli_o <= 1'b0;
            durum            <= BOSTA;
          end else if (bellek_kabul_i) begin
            bellek_gecerli_o <= 1'b0;
            durum            <= YANIT;
          end
        end
        YANIT: begin
          if (bellek_yanit_gecerli_i) begin
            yanit_hazir_o <= tek_bit(hibe);
            yanit_veri_o  <= bellek_yanit_veri_i;
            durum         <= BOSTA;
          end else if (zaman_asimi) begin
            yanit_hazir_o <= tek_bit(hibe);
            yanit_veri_o  <= '0;
            durum         <= BOSTA;
          end
        end
        default: begin
          bellek_gecerli_o <= 1'b0;
          durum            <= BOSTA;
        end
      endcase
    end
  end

endmodule
